// File: rtl/ram_dp_param.sv
// Simple dual-port RAM with a post-reset clear sequencer and write-first read bypass.
// Define RAMDP_OUTREG_EN to add an output register stage (read latency 2).
module ram_dp_param #(
    parameter int unsigned          DATA_W   = 8,
    parameter int unsigned          ADDR_W   = 4,
    parameter int unsigned          DEPTH    = 2 ** ADDR_W,
    parameter logic [DATA_W-1:0]    INIT_VAL = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] data,
    input  logic [ADDR_W-1:0] wraddress,
    input  logic              wren,
    input  logic [ADDR_W-1:0] rdaddress,
    input  logic              rden,
    output logic [DATA_W-1:0] q,
    output logic              q_valid,
    output logic              init_busy
);

    localparam logic [ADDR_W:0]   DepthLim = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

    typedef enum logic {StClear, StReady} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              wr_in_range, rd_in_range;
    logic              wr_ok, rd_ok;
    logic [DATA_W-1:0] rd_data_d, rd_data_q;
    logic              rd_valid_q;

    assign wr_in_range = {1'b0, wraddress} < DepthLim;
    assign rd_in_range = {1'b0, rdaddress} < DepthLim;
    assign init_busy   = (state_q == StClear);
    assign wr_ok       = (state_q == StReady) && wren && wr_in_range;
    assign rd_ok       = (state_q == StReady) && rden;

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (state_q == StClear) begin
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == LastAddr) begin
                state_d = StReady;
            end
        end
    end

    // Write-first: a same-edge write to the read address is forwarded to q.
    always_comb begin
        rd_data_d = '0;
        if (rd_in_range) begin
            if (wr_ok && (wraddress == rdaddress)) begin
                rd_data_d = data;
            end else begin
                rd_data_d = mem[rdaddress];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StClear;
            clr_cnt_q  <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            rd_valid_q <= rd_ok;
            if (rd_ok) begin
                rd_data_q <= rd_data_d;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            if (state_q == StClear) begin
                mem[clr_cnt_q] <= INIT_VAL;
            end else if (wr_ok) begin
                mem[wraddress] <= data;
            end
        end
    end

`ifdef RAMDP_OUTREG_EN
    logic [DATA_W-1:0] out_data_q;
    logic              out_valid_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_data_q  <= rd_data_q;
            out_valid_q <= rd_valid_q;
        end
    end

    assign q       = out_data_q;
    assign q_valid = out_valid_q;
`else
    assign q       = rd_data_q;
    assign q_valid = rd_valid_q;
`endif

endmodule

// File: tb/tb_ram_dp_param.sv
// Scoreboard bench for ram_dp_param: a 16-word instance and a 12-word variant.
// Expected read results are queued with their due cycle and checked by monitors.
module tb_ram_dp_param;

`ifdef RAMDP_OUTREG_EN
    localparam int Lat = 2;
`else
    localparam int Lat = 1;
`endif

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset = 1'b1;
    logic [7:0] data = '0, data_b = '0;
    logic [3:0] wraddress = '0, rdaddress = '0, wraddress_b = '0, rdaddress_b = '0;
    logic       wren = 1'b0, rden = 1'b0, wren_b = 1'b0, rden_b = 1'b0;
    logic [7:0] q, q_b;
    logic       q_valid, q_valid_b, init_busy, init_busy_b;

    ram_dp_param #(.DATA_W(8), .ADDR_W(4), .DEPTH(16), .INIT_VAL(8'hA5)) dut (
        .clock(clock), .reset(reset), .data(data), .wraddress(wraddress), .wren(wren),
        .rdaddress(rdaddress), .rden(rden), .q(q), .q_valid(q_valid), .init_busy(init_busy)
    );

    ram_dp_param #(.DATA_W(8), .ADDR_W(4), .DEPTH(12), .INIT_VAL(8'hA5)) dut_b (
        .clock(clock), .reset(reset), .data(data_b), .wraddress(wraddress_b), .wren(wren_b),
        .rdaddress(rdaddress_b), .rden(rden_b), .q(q_b), .q_valid(q_valid_b),
        .init_busy(init_busy_b)
    );

    typedef struct {
        logic [7:0] d;
        int         due;
    } exp_t;

    exp_t exp_a[$];
    exp_t exp_b[$];
    int   cyc  = 0;
    int   nvec = 0;
    int   nerr = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        nvec++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitors: each q_valid pulse must match the oldest queued read, on its due cycle.
    always @(negedge clock) begin
        exp_t e;
        if (q_valid === 1'b1) begin
            if (exp_a.size() == 0) begin
                check("a_spurious_q_valid", {31'b0, q_valid}, 32'd0);
            end else begin
                e = exp_a.pop_front();
                check("a_q", {24'b0, q}, {24'b0, e.d});
                check("a_latency", cyc, e.due);
            end
        end else if (exp_a.size() != 0 && exp_a[0].due <= cyc) begin
            check("a_missing_q_valid", {31'b0, q_valid}, 32'd1);
            void'(exp_a.pop_front());
        end
    end

    always @(negedge clock) begin
        exp_t e;
        if (q_valid_b === 1'b1) begin
            if (exp_b.size() == 0) begin
                check("b_spurious_q_valid", {31'b0, q_valid_b}, 32'd0);
            end else begin
                e = exp_b.pop_front();
                check("b_q", {24'b0, q_b}, {24'b0, e.d});
                check("b_latency", cyc, e.due);
            end
        end else if (exp_b.size() != 0 && exp_b[0].due <= cyc) begin
            check("b_missing_q_valid", {31'b0, q_valid_b}, 32'd1);
            void'(exp_b.pop_front());
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic rd_a(input logic [3:0] addr, input logic [7:0] exp);
        rden      = 1'b1;
        rdaddress = addr;
        exp_a.push_back('{d: exp, due: cyc + Lat});
        step();
    endtask

    task automatic rd_b(input logic [3:0] addr, input logic [7:0] exp);
        rden_b      = 1'b1;
        rdaddress_b = addr;
        exp_b.push_back('{d: exp, due: cyc + Lat});
        step();
    endtask

    task automatic wr_a(input logic [3:0] addr, input logic [7:0] d);
        wren      = 1'b1;
        wraddress = addr;
        data      = d;
        step();
        wren = 1'b0;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (init_busy === 1'b1 && n < 40) begin
            n++;
            step();
        end
    endtask

    initial begin
        int n;
        step();
        step();
        check("reset_q", {24'b0, q}, 32'h0);
        check("reset_q_valid", {31'b0, q_valid}, 32'd0);
        check("reset_init_busy", {31'b0, init_busy}, 32'd1);

        // Clear sequence, with port traffic that must be ignored while busy
        reset     = 1'b0;
        wren      = 1'b1;
        wraddress = 4'd3;
        data      = 8'h11;
        rden      = 1'b1;
        rdaddress = 4'd3;
        count_busy(n);
        wren = 1'b0;
        rden = 1'b0;
        check("clear_busy_cycles", n, 32'd16);
        for (int a = 0; a < 16; a++) rd_a(4'(a), 8'hA5);
        rden = 1'b0;

        // Write then back-to-back reads
        wr_a(4'd1, 8'h3C);
        wr_a(4'd2, 8'hC3);
        rd_a(4'd1, 8'h3C);
        rd_a(4'd2, 8'hC3);
        rden = 1'b0;

        // Write-first bypass on the same edge
        wren      = 1'b1;
        wraddress = 4'd5;
        data      = 8'h77;
        rd_a(4'd5, 8'h77);
        wren = 1'b0;
        rd_a(4'd5, 8'h77);
        rden = 1'b0;
        repeat (Lat + 2) step();
        check("hold_q", {24'b0, q}, 32'h77);
        check("hold_q_valid", {31'b0, q_valid}, 32'd0);

        // Reset mid-clear restarts the sequence; a dirtied word returns to INIT_VAL
        wr_a(4'd15, 8'h5A);
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (8) step();
        reset = 1'b1;
        step();
        check("midclear_busy_in_reset", {31'b0, init_busy}, 32'd1);
        reset = 1'b0;
        count_busy(n);
        check("midclear_busy_cycles", n, 32'd16);
        rd_a(4'd15, 8'hA5);
        rd_a(4'd1, 8'hA5);
        rden = 1'b0;

        // 12-word variant: out-of-range write dropped, out-of-range read returns 0
        check("b_ready", {31'b0, init_busy_b}, 32'd0);
        wren_b      = 1'b1;
        wraddress_b = 4'd13;
        data_b      = 8'h99;
        step();
        wraddress_b = 4'd11;
        data_b      = 8'h66;
        step();
        wren_b = 1'b0;
        rd_b(4'd13, 8'h00);
        rd_b(4'd12, 8'h00);
        rd_b(4'd11, 8'h66);
        rd_b(4'd0, 8'hA5);
        rden_b = 1'b0;

        repeat (Lat + 3) step();
        check("a_queue_drained", exp_a.size(), 32'd0);
        check("b_queue_drained", exp_b.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
